// File: rtl/movimenta_objeto.sv
// Position controller for the movable square: registers direction keys, resolves
// per-axis intent against collision flags once per movement tick, and steps xPos/yPos.
module movimenta_objeto #(
    parameter int TICK_DIV = 833333,
    parameter int PASSO    = 2,
    parameter int X_INI    = 120,
    parameter int Y_INI    = 130,
    parameter int X_MAX    = 640,
    parameter int Y_MAX    = 480,
    parameter int SETTLE   = 2
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic [6:0] tamanho,
    input  logic       tecla_cima,
    input  logic       tecla_baixo,
    input  logic       tecla_esq,
    input  logic       tecla_dir,
    input  logic       colisao_min_y,
    input  logic       colisao_max_y,
    input  logic       colisao_min_x,
    input  logic       colisao_max_x,
    output logic [9:0] xPos,
    output logic [8:0] yPos,
    output logic       passo_strobe,
    output logic       movendo
);

    localparam int              CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int              SW      = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0]   SET_MAX = SW'(SETTLE - 1);
    localparam logic [10:0]     PASSO_W = 11'(PASSO);
    localparam logic [10:0]     X_MAX_W = 11'(X_MAX);
    localparam logic [10:0]     Y_MAX_W = 11'(Y_MAX);

    typedef enum logic [1:0] {ESPERA, AVALIA, MOVE, ASSENTA} estado_t;

    estado_t               estado, prox_estado;
    logic [CW-1:0]         cnt;
    logic [SW-1:0]         settle_cnt;
    logic                  tick;
    logic                  eval_en, move_en, settle_en;
    logic [3:0]            teclas_p0;
    logic signed [1:0]     dx_p1, dy_p1;
    logic [10:0]           lim_x, lim_y;
    logic [9:0]            x_novo;
    logic [8:0]            y_novo;

    // Opposing keys cancel; a blocked direction resolves to no motion on that axis.
    function automatic logic signed [1:0] resolve(input logic neg, input logic pos,
                                                  input logic bloq_neg, input logic bloq_pos);
        if (neg && !pos && !bloq_neg)
            resolve = -2'sd1;
        else if (pos && !neg && !bloq_pos)
            resolve = 2'sd1;
        else
            resolve = 2'sd0;
    endfunction

    // Saturating step: floor at 0, ceiling at lim (also pulls an out-of-range coordinate back).
    function automatic logic [10:0] avanca(input logic [10:0] pos, input logic signed [1:0] d,
                                           input logic [10:0] lim);
        logic [10:0] soma;
        soma = pos + PASSO_W;
        if (d == -2'sd1)
            avanca = (pos < PASSO_W) ? 11'd0 : pos - PASSO_W;
        else if (d == 2'sd1)
            avanca = (soma > lim) ? lim : soma;
        else
            avanca = pos;
    endfunction

    always_ff @(posedge VGA_clk) begin
        if (reset)
            cnt <= '0;
        else if (cnt == CNT_MAX)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == CNT_MAX);

    // Stage p0: key capture
    always_ff @(posedge VGA_clk) begin
        if (reset)
            teclas_p0 <= 4'b0000;
        else
            teclas_p0 <= {tecla_cima, tecla_baixo, tecla_esq, tecla_dir};
    end

    always_ff @(posedge VGA_clk) begin
        if (reset)
            estado <= ESPERA;
        else
            estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            ESPERA:  if (tick) prox_estado = AVALIA;
            AVALIA:  prox_estado = MOVE;
            MOVE:    prox_estado = ASSENTA;
            ASSENTA: if (settle_cnt == SET_MAX) prox_estado = ESPERA;
            default: prox_estado = ESPERA;
        endcase
    end

    always_comb begin
        eval_en   = (estado == AVALIA);
        move_en   = (estado == MOVE);
        settle_en = (estado == ASSENTA);
    end

    always_ff @(posedge VGA_clk) begin
        if (reset || move_en)
            settle_cnt <= '0;
        else if (settle_en)
            settle_cnt <= settle_cnt + SW'(1);
    end

    // Stage p1: per-axis intent
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            dx_p1 <= 2'sd0;
            dy_p1 <= 2'sd0;
        end else if (eval_en) begin
            dy_p1 <= resolve(teclas_p0[3], teclas_p0[2], colisao_min_y, colisao_max_y);
            dx_p1 <= resolve(teclas_p0[1], teclas_p0[0], colisao_min_x, colisao_max_x);
        end
    end

    always_comb begin
        lim_x  = X_MAX_W - {4'b0000, tamanho};
        lim_y  = Y_MAX_W - {4'b0000, tamanho};
        x_novo = 10'(avanca({1'b0, xPos}, dx_p1, lim_x));
        y_novo = 9'(avanca({2'b00, yPos}, dy_p1, lim_y));
    end

    // Stage p2: position update
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            xPos         <= 10'(X_INI);
            yPos         <= 9'(Y_INI);
            passo_strobe <= 1'b0;
            movendo      <= 1'b0;
        end else begin
            passo_strobe <= move_en;
            if (move_en) begin
                xPos    <= x_novo;
                yPos    <= y_novo;
                movendo <= (x_novo != xPos) || (y_novo != yPos);
            end
        end
    end

endmodule

// File: tb/tb_movimenta_objeto.sv
// Directed bench for movimenta_objeto: a main instance at the default start point
// and a second instance started next to both clamp limits.
module tb_movimenta_objeto;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] tamanho;
    logic       cima, baixo, esq, dir;
    logic       col_min_y, col_max_y, col_min_x, col_max_x;
    logic [9:0] xpos;
    logic [8:0] ypos;
    logic       strobe, mov;

    logic       c_cima, c_dir;
    logic [9:0] c_x;
    logic [8:0] c_y;
    logic       c_strobe, c_mov;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    movimenta_objeto #(.TICK_DIV(8), .PASSO(2), .X_INI(120), .Y_INI(130),
                       .X_MAX(640), .Y_MAX(480), .SETTLE(2)) dut (
        .VGA_clk(clk), .reset(reset), .tamanho(tamanho),
        .tecla_cima(cima), .tecla_baixo(baixo), .tecla_esq(esq), .tecla_dir(dir),
        .colisao_min_y(col_min_y), .colisao_max_y(col_max_y),
        .colisao_min_x(col_min_x), .colisao_max_x(col_max_x),
        .xPos(xpos), .yPos(ypos), .passo_strobe(strobe), .movendo(mov)
    );

    movimenta_objeto #(.TICK_DIV(8), .PASSO(2), .X_INI(619), .Y_INI(1),
                       .X_MAX(640), .Y_MAX(480), .SETTLE(2)) u_clamp (
        .VGA_clk(clk), .reset(reset), .tamanho(tamanho),
        .tecla_cima(c_cima), .tecla_baixo(1'b0), .tecla_esq(1'b0), .tecla_dir(c_dir),
        .colisao_min_y(1'b0), .colisao_max_y(1'b0),
        .colisao_min_x(1'b0), .colisao_max_x(1'b0),
        .xPos(c_x), .yPos(c_y), .passo_strobe(c_strobe), .movendo(c_mov)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after posedge number k (counted from reset release).
    task automatic adv_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        reset = 1'b1; tamanho = 7'd20;
        cima = 0; baixo = 0; esq = 0; dir = 0;
        col_min_y = 0; col_max_y = 0; col_min_x = 0; col_max_x = 0;
        c_cima = 0; c_dir = 0;
        repeat (3) @(posedge clk);
        #1;
        cyc = 0;
        chk("rst_x", int'(xpos), 120);
        chk("rst_y", int'(ypos), 130);
        chk("rst_strobe", int'(strobe), 0);
        chk("rst_mov", int'(mov), 0);
        chk("rst_clamp_x", int'(c_x), 619);
        chk("rst_clamp_y", int'(c_y), 1);
        reset = 1'b0;
        cima = 1; c_cima = 1; c_dir = 1;

        adv_to(9);
        chk("up_pre_y", int'(ypos), 130);
        chk("up_pre_strobe", int'(strobe), 0);
        adv_to(10);
        chk("up1_y", int'(ypos), 128);
        chk("up1_strobe", int'(strobe), 1);
        chk("up1_mov", int'(mov), 1);
        chk("clamp1_y", int'(c_y), 0);
        chk("clamp1_x", int'(c_x), 620);
        chk("clamp1_mov", int'(c_mov), 1);
        adv_to(11);
        chk("strobe_one_cycle", int'(strobe), 0);
        adv_to(14);
        chk("hold_y", int'(ypos), 128);
        adv_to(18);
        chk("up2_y", int'(ypos), 126);
        chk("up2_strobe", int'(strobe), 1);
        chk("clamp2_y", int'(c_y), 0);
        chk("clamp2_x", int'(c_x), 620);
        chk("clamp2_mov", int'(c_mov), 0);
        chk("clamp2_strobe", int'(c_strobe), 1);

        adv_to(19);
        col_min_y = 1;
        adv_to(26);
        chk("blk_y", int'(ypos), 126);
        chk("blk_strobe", int'(strobe), 1);
        chk("blk_mov", int'(mov), 0);

        adv_to(27);
        col_min_y = 0; baixo = 1; dir = 1;
        adv_to(34);
        chk("diag_y", int'(ypos), 126);
        chk("diag_x", int'(xpos), 122);
        chk("diag_mov", int'(mov), 1);
        chk("diag_strobe", int'(strobe), 1);

        adv_to(35);
        baixo = 0; dir = 0;
        adv_to(41);
        reset = 1'b1;
        adv_to(42);
        reset = 1'b0;
        chk("mid_rst_x", int'(xpos), 120);
        chk("mid_rst_y", int'(ypos), 130);
        chk("mid_rst_strobe", int'(strobe), 0);
        chk("mid_rst_mov", int'(mov), 0);
        adv_to(43);
        chk("mid_rst_no_strobe", int'(strobe), 0);
        adv_to(50);
        chk("restart_y50", int'(ypos), 130);
        chk("restart_strobe50", int'(strobe), 0);
        adv_to(51);
        chk("restart_y51", int'(ypos), 130);
        adv_to(52);
        chk("restart_y52", int'(ypos), 128);
        chk("restart_strobe52", int'(strobe), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
